gcd_job_sequencer: RTL and testbench
====================================

// Module: gcd_job_sequencer
// PURPOSE
//  Initiator for the GCD core's ld/U/V -> res/done interface: buffers operand pairs arriving
//  on a valid/ready stream and issues them one at a time to the GCD core. Waits for the core's
//  done and returns {U,V,res} on an output valid/ready stream. Sits between the job source
//  and the GCD core; bypasses the core for zero operands; flags hung jobs via a timeout.
// PARAMETERS
//  WIDTH    8     operand/result width in bits, matches the GCD core
//  DEPTH    4     input FIFO entries; power of 2, >= 2
//  TIMEOUT  1023  max cycles in WAIT before the job is aborted; must be >= 1
// PORTS
//  clk        in   1      clock, rising edge
//  reset      in   1      asynchronous reset, active-high
//  in_valid   in   1      operand pair valid
//  in_ready   out  1      FIFO not full; a pair is accepted on a clk edge with in_valid & in_ready
//  in_u       in   WIDTH  operand U
//  in_v       in   WIDTH  operand V
//  gcd_ld     out  1      one-cycle load pulse to the GCD core
//  gcd_u      out  WIDTH  U to the core; held stable from ld until the job completes
//  gcd_v      out  WIDTH  V to the core; held stable from ld until the job completes
//  gcd_res    in   WIDTH  core result; valid when gcd_done rises
//  gcd_done   in   1      core done; level, may remain high until the next ld
//  out_valid  out  1      result valid; held until accepted
//  out_ready  in   1      consumer ready
//  out_u      out  WIDTH  echoed U of the completed job
//  out_v      out  WIDTH  echoed V of the completed job
//  out_res    out  WIDTH  GCD(U,V); 0 on timeout
//  out_err    out  1      1 = job aborted by timeout
//  busy       out  1      FSM not in IDLE, or FIFO not empty
// BEHAVIOUR
//  Reset (async, high): FIFO empty, FSM=IDLE, done_q=0, timer=0. All outputs 0 except
//   in_ready=1.
//  FIFO: push = in_valid & in_ready; pop only in IDLE when not empty. No fall-through: a pair
//   pushed at edge k is popped at edge k+1 at earliest. in_ready = !full, registered count.
//   Push and pop in the same cycle: count is unchanged. Pointers wrap modulo DEPTH.
//  done_q: registers gcd_done every cycle. done_rise = gcd_done & !done_q.
//  FSM:
//   IDLE: if FIFO not empty, pop into job regs (gcd_u/gcd_v). If either operand is 0,
//    go to OUT with res = U|V, err=0; 0,0 -> 0, and no ld is issued. Otherwise go to ISSUE.
//   ISSUE: gcd_ld=1 for exactly this cycle; clear timer; go to WAIT.
//   WAIT: on done_rise, capture gcd_res into out_res with err=0 and go to OUT. A done level
//    that was already high when ld was issued is ignored until it falls and rises again.
//    The timer increments each cycle. At timer==TIMEOUT-1 with no done_rise, go to OUT with
//    out_res=0 and err=1. A done_rise in the same cycle as the timeout wins: no error.
//   OUT: out_valid=1, with out_u/out_v/out_res/out_err stable. On out_ready, go to IDLE
//    (out_valid drops the next cycle). A FIFO pop can happen in the following IDLE cycle.
//  Latency, non-zero job, empty pipe, out_ready=1: push@k, pop@k+1, ld during k+2,
//   out_valid from (done_rise edge)+1. Zero-bypass: out_valid in cycle k+2.
//  One job in flight; results return in push order.
//  Reset mid-job: everything aborts immediately and no output is produced. gcd_ld=0 during
//   reset. Queued pairs are lost.
//  Widths: all data paths are WIDTH bits; no arithmetic beyond the zero test and U|V.
// TESTING (bench includes a behavioural GCD core model with a random 3-40 cycle latency
//  and done held high until the next ld)
//  1. Push (48,18) -> exactly one gcd_ld pulse with gcd_u=48, gcd_v=18; out_res=6,
//     out_err=0, out_u=48, out_v=18.
//  2. Push (0,35), (27,0), (0,0) -> results 35, 27, 0. gcd_ld never asserts.
//  3. DEPTH=4, out_ready=0, push 6 pairs back-to-back -> in_ready low after 5 accepts
//     (4 in FIFO + 1 in flight). Release out_ready -> all results arrive in order.
//  4. out_ready held low 20 cycles after out_valid -> out_* stable, no new gcd_ld until
//     accepted.
//  5. TIMEOUT=16, core never raises done -> out_valid at WAIT+16, out_err=1, out_res=0.
//     The next job completes normally.
//  6. Assert reset during WAIT with 2 pairs queued -> out_valid=0, in_ready=1, busy=0.
//     A new push (100,75) -> 25.

Source files
------------

// File: rtl/gcd_job_sequencer.sv
// gcd_job_sequencer
//   Buffers (U,V) operand pairs from a valid/ready stream in a small FIFO and issues them one
//   at a time to a GCD core over its ld/U/V -> res/done interface. A completed job is returned
//   as {U,V,res,err} on an output valid/ready stream. Pairs with a zero operand are answered
//   without involving the core. A job whose done never arrives is aborted by a timeout.
// Ports
//   clk, reset                    clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready/in_u/in_v   operand stream; in_ready = FIFO not full
//   gcd_ld/gcd_u/gcd_v            one-cycle load pulse and held operands to the core
//   gcd_res/gcd_done              core result and level done
//   out_valid/out_ready           result stream handshake
//   out_u/out_v/out_res/out_err   echoed operands, GCD (0 on timeout), timeout flag
//   busy                          FSM not idle or FIFO not empty
module gcd_job_sequencer #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_u,
    input  logic [WIDTH-1:0] in_v,
    output logic             gcd_ld,
    output logic [WIDTH-1:0] gcd_u,
    output logic [WIDTH-1:0] gcd_v,
    input  logic [WIDTH-1:0] gcd_res,
    input  logic             gcd_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_u,
    output logic [WIDTH-1:0] out_v,
    output logic [WIDTH-1:0] out_res,
    output logic             out_err,
    output logic             busy
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    // Timer only needs to reach TIMEOUT-1.
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CountFull = CW'(DEPTH);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StOut} state_e;

    state_e             state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0]   job_u_q, job_u_d;
    logic [WIDTH-1:0]   job_v_q, job_v_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               done_q;
    logic               ld_q, ld_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_res_q, out_res_d;
    logic               out_err_q, out_err_d;

    logic               push, pop, done_rise;
    logic [WIDTH-1:0]   head_u, head_v;

    assign in_ready  = (count_q != CountFull);
    assign push      = in_valid & in_ready;
    // Pop only from IDLE, using the registered count, so a pair is never popped on the
    // same edge that pushes it.
    assign pop       = (state_q == StIdle) && (count_q != '0);
    // A done level already high at ld time is masked until it falls and rises again.
    assign done_rise = gcd_done & ~done_q;
    assign head_u    = mem_q[rd_ptr_q][2*WIDTH-1:WIDTH];
    assign head_v    = mem_q[rd_ptr_q][WIDTH-1:0];

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        job_u_d     = job_u_q;
        job_v_d     = job_v_q;
        timer_d     = timer_q;
        out_res_d   = out_res_q;
        out_err_d   = out_err_q;

        // Pointers wrap naturally since DEPTH is a power of two.
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    job_u_d = head_u;
                    job_v_d = head_v;
                    if ((head_u == '0) || (head_v == '0)) begin
                        // GCD(x,0) = x, GCD(0,0) reported as 0: no core involvement.
                        out_res_d = head_u | head_v;
                        out_err_d = 1'b0;
                        state_d   = StOut;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                timer_d = '0;
                state_d = StWait;
            end
            StWait: begin
                if (done_rise) begin
                    out_res_d = gcd_res;
                    out_err_d = 1'b0;
                    state_d   = StOut;
                end else if (timer_q == TimerLast) begin
                    out_res_d = '0;
                    out_err_d = 1'b1;
                    state_d   = StOut;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StOut: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        ld_d        = (state_d == StIssue);
        out_valid_d = (state_d == StOut);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            job_u_q     <= '0;
            job_v_q     <= '0;
            timer_q     <= '0;
            done_q      <= 1'b0;
            ld_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_res_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            job_u_q     <= job_u_d;
            job_v_q     <= job_v_d;
            timer_q     <= timer_d;
            done_q      <= gcd_done;
            ld_q        <= ld_d;
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            out_err_q   <= out_err_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_u, in_v};
        end
    end

    assign gcd_ld    = ld_q;
    assign gcd_u     = job_u_q;
    assign gcd_v     = job_v_q;
    assign out_valid = out_valid_q;
    assign out_u     = job_u_q;
    assign out_v     = job_v_q;
    assign out_res   = out_res_q;
    assign out_err   = out_err_q;
    assign busy      = (state_q != StIdle) || (count_q != '0);

endmodule

// File: tb/tb_gcd_job_sequencer.sv
// tb_gcd_job_sequencer
//   Directed bench for gcd_job_sequencer. Instance A uses default parameters with a GCD core
//   model of random 3-40 cycle latency; instance B uses TIMEOUT=16 with a core model that can
//   be made to hang. Expected results are hand-computed constants.
`timescale 1ns/1ps

module tb_gcd_job_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    int total  = 0;
    int passes = 0;
    int fails  = 0;

    // Instance A signals
    logic       in_valid, in_ready, gcd_ld, gcd_done, out_valid, out_ready, out_err, busy;
    logic [7:0] in_u, in_v, gcd_u, gcd_v, gcd_res, out_u, out_v, out_res;

    // Instance B signals
    logic       b_in_valid, b_in_ready, b_gcd_ld, b_gcd_done, b_out_valid, b_out_ready;
    logic       b_out_err, b_busy;
    logic [7:0] b_in_u, b_in_v, b_gcd_u, b_gcd_v, b_gcd_res, b_out_u, b_out_v, b_out_res;

    gcd_job_sequencer #(.WIDTH(8), .DEPTH(4), .TIMEOUT(1023)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_u      (in_u),
        .in_v      (in_v),
        .gcd_ld    (gcd_ld),
        .gcd_u     (gcd_u),
        .gcd_v     (gcd_v),
        .gcd_res   (gcd_res),
        .gcd_done  (gcd_done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_u     (out_u),
        .out_v     (out_v),
        .out_res   (out_res),
        .out_err   (out_err),
        .busy      (busy)
    );

    gcd_job_sequencer #(.WIDTH(8), .DEPTH(4), .TIMEOUT(16)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_u      (b_in_u),
        .in_v      (b_in_v),
        .gcd_ld    (b_gcd_ld),
        .gcd_u     (b_gcd_u),
        .gcd_v     (b_gcd_v),
        .gcd_res   (b_gcd_res),
        .gcd_done  (b_gcd_done),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_u     (b_out_u),
        .out_v     (b_out_v),
        .out_res   (b_out_res),
        .out_err   (b_out_err),
        .busy      (b_busy)
    );

    function automatic logic [7:0] gcd_fn(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] x, y, t;
        x = a;
        y = b;
        while (y != 0) begin
            t = y;
            y = x % y;
            x = t;
        end
        return x;
    endfunction

    task automatic check(input string tag, input logic ok, input longint obs, input longint exp);
        total++;
        if (ok === 1'b1) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Core model A: random latency, done held high until the next ld.
    logic a_core_busy;
    int   a_lat;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            gcd_done    <= 1'b0;
            gcd_res     <= 8'h00;
            a_core_busy <= 1'b0;
            a_lat       <= 0;
        end else if (gcd_ld) begin
            gcd_done    <= 1'b0;
            gcd_res     <= gcd_fn(gcd_u, gcd_v);
            a_lat       <= int'($urandom_range(40, 3));
            a_core_busy <= 1'b1;
        end else if (a_core_busy) begin
            if (a_lat <= 1) begin
                gcd_done    <= 1'b1;
                a_core_busy <= 1'b0;
            end else begin
                a_lat <= a_lat - 1;
            end
        end
    end

    // Core model B: fixed 5-cycle latency unless hung.
    logic b_hang;
    logic b_core_busy;
    int   b_lat;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            b_gcd_done  <= 1'b0;
            b_gcd_res   <= 8'h00;
            b_core_busy <= 1'b0;
            b_lat       <= 0;
        end else if (b_gcd_ld) begin
            b_gcd_done  <= 1'b0;
            b_gcd_res   <= gcd_fn(b_gcd_u, b_gcd_v);
            b_lat       <= 5;
            b_core_busy <= !b_hang;
        end else if (b_core_busy) begin
            if (b_lat <= 1) begin
                b_gcd_done  <= 1'b1;
                b_core_busy <= 1'b0;
            end else begin
                b_lat <= b_lat - 1;
            end
        end
    end

    int         ld_count = 0;
    int         b_ld_count = 0;
    logic [7:0] ld_u, ld_v;
    always @(posedge clk) begin
        if (gcd_ld) begin
            ld_count <= ld_count + 1;
            ld_u     <= gcd_u;
            ld_v     <= gcd_v;
        end
        if (b_gcd_ld) begin
            b_ld_count <= b_ld_count + 1;
        end
    end

    // Called at a negedge; returns at a negedge after the pair was accepted.
    task automatic push(input logic [7:0] u, input logic [7:0] v);
        int n = 0;
        in_u     = u;
        in_v     = v;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", in_ready === 1'b1, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic [7:0] eu, input logic [7:0] ev,
                              input logic [7:0] eres, input logic eerr);
        int n = 0;
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, out_valid === 1'b1, out_valid, 1);
        check({tag, "_u"}, out_u === eu, out_u, eu);
        check({tag, "_v"}, out_v === ev, out_v, ev);
        check({tag, "_res"}, out_res === eres, out_res, eres);
        check({tag, "_err"}, out_err === eerr, out_err, eerr);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    logic [7:0] t3_u [8];
    logic [7:0] t3_v [8];

    initial begin
        int ld_base;
        int idx;
        int n;
        logic acc;
        logic bad;

        reset       = 1'b1;
        in_valid    = 1'b0;
        in_u        = 8'h00;
        in_v        = 8'h00;
        out_ready   = 1'b0;
        b_in_valid  = 1'b0;
        b_in_u      = 8'h00;
        b_in_v      = 8'h00;
        b_out_ready = 1'b0;
        b_hang      = 1'b0;
        t3_u = '{8'd12, 8'd9, 8'd100, 8'd17, 8'd81, 8'd14, 8'd0, 8'd0};
        t3_v = '{8'd8,  8'd6, 8'd10,  8'd5,  8'd27, 8'd21, 8'd0, 8'd0};

        repeat (3) @(negedge clk);
        check("rst_ld_during", gcd_ld === 1'b0, gcd_ld, 0);
        reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready === 1'b1, in_ready, 1);
        check("rst_out_valid", out_valid === 1'b0, out_valid, 0);
        check("rst_busy", busy === 1'b0, busy, 0);
        check("rst_out_res", out_res === 8'h00, out_res, 0);
        check("rst_out_err", out_err === 1'b0, out_err, 0);
        check("rst_gcd_u", gcd_u === 8'h00, gcd_u, 0);

        // 1: single normal job
        ld_base = ld_count;
        push(8'd48, 8'd18);
        get_result("t1", 8'd48, 8'd18, 8'd6, 1'b0);
        check("t1_ld_pulses", (ld_count - ld_base) === 1, ld_count - ld_base, 1);
        check("t1_ld_u", ld_u === 8'd48, ld_u, 48);
        check("t1_ld_v", ld_v === 8'd18, ld_v, 18);

        // 2: zero-operand bypass
        ld_base = ld_count;
        push(8'd0, 8'd35);
        push(8'd27, 8'd0);
        push(8'd0, 8'd0);
        get_result("t2a", 8'd0, 8'd35, 8'd35, 1'b0);
        get_result("t2b", 8'd27, 8'd0, 8'd27, 1'b0);
        get_result("t2c", 8'd0, 8'd0, 8'd0, 1'b0);
        check("t2_no_ld", (ld_count - ld_base) === 0, ld_count - ld_base, 0);

        // 3: back-pressure, FIFO fills after 5 accepts
        ld_base = ld_count;
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            in_valid = (idx < 6);
            in_u     = t3_u[idx];
            in_v     = t3_v[idx];
            acc      = in_valid && in_ready;
            @(negedge clk);
            if (acc) idx++;
        end
        in_valid = 1'b0;
        check("t3_accepts", idx === 5, idx, 5);
        check("t3_in_ready_low", in_ready === 1'b0, in_ready, 0);
        check("t3_one_ld", (ld_count - ld_base) === 1, ld_count - ld_base, 1);
        get_result("t3_0", 8'd12, 8'd8, 8'd4, 1'b0);
        push(t3_u[5], t3_v[5]);
        get_result("t3_1", 8'd9, 8'd6, 8'd3, 1'b0);
        get_result("t3_2", 8'd100, 8'd10, 8'd10, 1'b0);
        get_result("t3_3", 8'd17, 8'd5, 8'd1, 1'b0);
        get_result("t3_4", 8'd81, 8'd27, 8'd27, 1'b0);
        get_result("t3_5", 8'd14, 8'd21, 8'd7, 1'b0);

        // 4: output held under back-pressure, no new ld
        push(8'd48, 8'd36);
        push(8'd35, 8'd14);
        n = 0;
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        ld_base = ld_count;
        bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid !== 1'b1 || out_u !== 8'd48 || out_v !== 8'd36 ||
                out_res !== 8'd12 || out_err !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        check("t4_stable", bad === 1'b0, bad, 0);
        check("t4_no_ld", (ld_count - ld_base) === 0, ld_count - ld_base, 0);
        get_result("t4a", 8'd48, 8'd36, 8'd12, 1'b0);
        get_result("t4b", 8'd35, 8'd14, 8'd7, 1'b0);

        // 5: timeout on instance B (TIMEOUT=16)
        b_hang     = 1'b1;
        b_in_u     = 8'd9;
        b_in_v     = 8'd3;
        b_in_valid = 1'b1;
        @(negedge clk);
        b_in_valid = 1'b0;
        n = 0;
        while (!b_gcd_ld && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t5_ld_seen", b_gcd_ld === 1'b1, b_gcd_ld, 1);
        n = 0;
        while (!b_out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t5_timeout_cycles", n === 17, n, 17);
        check("t5_err", b_out_err === 1'b1, b_out_err, 1);
        check("t5_res", b_out_res === 8'h00, b_out_res, 0);
        check("t5_u", b_out_u === 8'd9, b_out_u, 9);
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
        b_hang      = 1'b0;
        b_in_u      = 8'd21;
        b_in_v      = 8'd14;
        b_in_valid  = 1'b1;
        @(negedge clk);
        b_in_valid = 1'b0;
        n = 0;
        while (!b_out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t5b_valid", b_out_valid === 1'b1, b_out_valid, 1);
        check("t5b_res", b_out_res === 8'd7, b_out_res, 7);
        check("t5b_err", b_out_err === 1'b0, b_out_err, 0);
        check("t5b_ld_count", b_ld_count === 2, b_ld_count, 2);
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;

        // 6: reset during WAIT with two pairs queued
        ld_base = ld_count;
        push(8'd30, 8'd12);
        push(8'd40, 8'd16);
        push(8'd50, 8'd20);
        check("t6_busy_before", busy === 1'b1, busy, 1);
        check("t6_ld_before", (ld_count - ld_base) === 1, ld_count - ld_base, 1);
        reset = 1'b1;
        #1;
        check("t6_out_valid", out_valid === 1'b0, out_valid, 0);
        check("t6_in_ready", in_ready === 1'b1, in_ready, 1);
        check("t6_busy", busy === 1'b0, busy, 0);
        check("t6_ld", gcd_ld === 1'b0, gcd_ld, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_still_idle", busy === 1'b0, busy, 0);
        ld_base = ld_count;
        push(8'd100, 8'd75);
        get_result("t6", 8'd100, 8'd75, 8'd25, 1'b0);
        check("t6_ld_after", (ld_count - ld_base) === 1, ld_count - ld_base, 1);
        check("t6_ld_u", ld_u === 8'd100, ld_u, 100);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed=running expected=done");
        $fatal(1, "watchdog");
    end

endmodule
